// File: rtl/music_box_pkg.sv
// Shared encodings for the music box: system states, audio source ids and
// the DAC sample scheduler FSM.
package music_box_pkg;

  localparam logic [4:0] DoNothing     = 5'd0;
  localparam logic [4:0] PlaySong0     = 5'd1;
  localparam logic [4:0] PlaySong1     = 5'd2;
  localparam logic [4:0] MakeRecording = 5'd3;
  localparam logic [4:0] PlayRecording = 5'd4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_KEY  = 2'd1,
    SRC_SONG = 2'd2,
    SRC_REC  = 2'd3
  } source_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_e;

  function automatic source_e selectSource(input logic [4:0] st);
    case (st)
      DoNothing, MakeRecording: return SRC_KEY;
      PlaySong0, PlaySong1:     return SRC_SONG;
      PlayRecording:            return SRC_REC;
      default:                  return SRC_NONE;
    endcase
  endfunction

  // One-hot consume mask: [0] key, [1] song, [2] rec.
  function automatic logic [2:0] ackMask(input source_e src);
    case (src)
      SRC_KEY:  return 3'b001;
      SRC_SONG: return 3'b010;
      SRC_REC:  return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sample_tick_generator.sv
// Free-running divider producing a registered one-cycle tick every DIVIDE
// clocks; the tick is high while the counter sits at DIVIDE-1.
module sample_tick_generator #(
  parameter int DIVIDE = 1562
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

  logic [CW-1:0] count;
  logic [CW-1:0] countNext;

  assign countNext = (count == CW'(DIVIDE - 1)) ? '0 : count + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= countNext;
      tick  <= (countNext == CW'(DIVIDE - 1));
    end
  end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces samples to the SPI DAC controller: one source pick per tick, send
// handshake, consume ack, overrun counting and request timeout detection.
module dac_sample_scheduler
  import music_box_pkg::*;
#(
  parameter int SAMPLE_DIVIDE = 1562,
  parameter int DATA_W        = 12,
  parameter int REQ_TIMEOUT   = 64,
  parameter int SILENCE       = 2048
) (
  input  logic              clock_50Mhz,
  input  logic              reset_n,
  input  logic [4:0]        currentState,
  input  logic [DATA_W-1:0] key_sample,
  input  logic [DATA_W-1:0] song_sample,
  input  logic [DATA_W-1:0] rec_sample,
  input  logic              key_valid,
  input  logic              song_valid,
  input  logic              rec_valid,
  output logic [2:0]        source_ack,
  output logic [DATA_W-1:0] dac_inputSample,
  output logic              dac_sendSample_n,
  input  logic              dac_isBusy,
  input  logic              dac_transmitComplete,
  output logic              sample_tick,
  output logic [1:0]        active_source,
  output logic [15:0]       overrun_count,
  output logic              timeout_error,
  input  logic              clear_status
);

  localparam int TW = $clog2(REQ_TIMEOUT + 1);

  sched_state_e      state, stateNext;
  logic [TW-1:0]     reqCount;
  source_e           sel, frameSrc;
  logic [DATA_W-1:0] frameSample;
  logic              accept, reqTimeout, lostTick;

  sample_tick_generator #(.DIVIDE(SAMPLE_DIVIDE)) u_tick (
    .clk   (clock_50Mhz),
    .rst_n (reset_n),
    .tick  (sample_tick)
  );

  assign sel = selectSource(currentState);

  // An invalid selected source degrades to silence with no consume pulse.
  always_comb begin
    frameSample = DATA_W'(SILENCE);
    frameSrc    = SRC_NONE;
    unique case (sel)
      SRC_KEY:  if (key_valid)  begin frameSample = key_sample;  frameSrc = SRC_KEY;  end
      SRC_SONG: if (song_valid) begin frameSample = song_sample; frameSrc = SRC_SONG; end
      SRC_REC:  if (rec_valid)  begin frameSample = rec_sample;  frameSrc = SRC_REC;  end
      default: ;
    endcase
  end

  assign accept     = (state == IDLE) && sample_tick;
  assign lostTick   = (state != IDLE) && sample_tick;
  assign reqTimeout = (state == REQUEST) && !dac_isBusy &&
                      (reqCount == TW'(REQ_TIMEOUT - 1));

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (sample_tick) stateNext = REQUEST;
      REQUEST:   if (dac_isBusy) stateNext = WAIT_DONE;
                 else if (reqTimeout) stateNext = IDLE;
      WAIT_DONE: if (dac_transmitComplete) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  // Every output is a flop; send request tracks the upcoming state.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      dac_inputSample  <= DATA_W'(SILENCE);
      dac_sendSample_n <= 1'b1;
      source_ack       <= '0;
      active_source    <= SRC_NONE;
      overrun_count    <= '0;
      timeout_error    <= 1'b0;
      reqCount         <= '0;
    end else begin
      dac_sendSample_n <= (stateNext != REQUEST);
      source_ack       <= '0;
      reqCount         <= (state == REQUEST) ? reqCount + 1'b1 : '0;
      if (accept) begin
        dac_inputSample <= frameSample;
        active_source   <= frameSrc;
        source_ack      <= ackMask(frameSrc);
      end
      if (clear_status) begin
        overrun_count <= '0;
        timeout_error <= 1'b0;
      end else begin
        if (lostTick && overrun_count != 16'hFFFF) overrun_count <= overrun_count + 1'b1;
        if (reqTimeout) timeout_error <= 1'b1;
      end
    end
  end

endmodule
